// File: rtl/aes_encrypt_iter_if.sv
// aes_encrypt_iter_if: valid/ready plaintext-in / ciphertext-out bus for the
// iterative AES-128 encrypt core.
//   in_valid/in_ready/in_data    : plaintext block from producer to core
//   out_valid/out_ready/out_data : ciphertext block from core to consumer
// modport master : producer/consumer side (drives in_*, out_ready)
// modport slave  : the core (drives in_ready, out_valid, out_data)
interface aes_encrypt_iter_if;
  localparam int unsigned DATA_W = 128;

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;

  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data
  );
endinterface

// File: rtl/aes_encrypt_iter.sv
// aes_encrypt_iter: iterative AES-128 encryption, one cipher round per clock.
//   clk      : rising-edge clock
//   rst      : asynchronous active-high reset
//   all_keys : flattened round keys, key i at all_keys[128*(i+1)-1 -: 128]
//   bus      : aes_encrypt_iter_if.slave (plaintext in, ciphertext out)
// Optional macro AES_ENC_DBG_EN adds dbg_round (round counter, 0 outside RUN)
// and dbg_state (state register) outputs.
// all_keys is not captured; it must stay stable from accept to out handshake.
module aes_encrypt_iter #(
  parameter int unsigned NK = 4,
  parameter int unsigned NR = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [(NR+1)*128-1:0]  all_keys,
  aes_encrypt_iter_if.slave      bus
`ifdef AES_ENC_DBG_EN
  ,
  output logic [3:0]             dbg_round,
  output logic [127:0]           dbg_state
`endif
);

  localparam int unsigned BLK_W = 128;
  localparam int unsigned RND_W = 4;

  // Only AES-128 geometry is supported.
  if ((NK != 4) || (NR != 10)) begin : g_bad_cfg
    $error("aes_encrypt_iter supports only NK=4, NR=10");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_e;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // SubBytes: byte-wise S-box substitution.
  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      r[8*i +: 8] = SBOX[s[8*i +: 8]];
    end
    return r;
  endfunction

  // ShiftRows: byte (row w, col c) takes byte (w, (c+w) mod 4); byte k = w + 4c.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int w = 0; w < 4; w++) begin
        r[127-8*(w+4*c) -: 8] = s[127-8*(w+4*((c+w)%4)) -: 8];
      end
    end
    return r;
  endfunction

  // Multiply by x in GF(2^8) mod x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // MixColumns: each column times circulant {02,03,01,01}.
  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] r;
    logic [7:0]   a0, a1, a2, a3;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      r[127-32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                           a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                           a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                           xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    end
    return r;
  endfunction

  // Unflatten the round-key bus.
  logic [BLK_W-1:0] rk [NR+1];
  for (genvar i = 0; i < NR + 1; i++) begin : g_rk
    assign rk[i] = all_keys[BLK_W*(i+1)-1 -: BLK_W];
  end

  fsm_e             fsm_q, fsm_n;
  logic [RND_W-1:0] round_q, round_n;
  logic [BLK_W-1:0] state_q, state_n;
  logic             in_ready_q;
  logic             out_valid_q;

  // Round datapath shared by the middle and final rounds.
  logic [BLK_W-1:0] sr_sb_c;
  logic [BLK_W-1:0] mix_c;
  assign sr_sb_c = shift_rows(sub_bytes(state_q));
  assign mix_c   = mix_columns(sr_sb_c);

  // Next-state logic.
  always_comb begin
    fsm_n   = fsm_q;
    round_n = round_q;
    state_n = state_q;
    case (fsm_q)
      IDLE: begin
        if (bus.in_valid) begin
          state_n = bus.in_data ^ rk[0];
          round_n = RND_W'(1);
          fsm_n   = RUN;
        end
      end
      RUN: begin
        if (round_q == RND_W'(NR)) begin
          state_n = sr_sb_c ^ rk[NR];
          round_n = '0;
          fsm_n   = DONE;
        end else begin
          state_n = mix_c ^ rk[round_q];
          round_n = round_q + RND_W'(1);
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          fsm_n = IDLE;
        end
      end
      default: begin
        fsm_n   = IDLE;
        round_n = '0;
      end
    endcase
  end

  // State register; handshake flags are registered copies of the next FSM state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q       <= IDLE;
      round_q     <= '0;
      state_q     <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      fsm_q       <= fsm_n;
      round_q     <= round_n;
      state_q     <= state_n;
      in_ready_q  <= (fsm_n == IDLE);
      out_valid_q <= (fsm_n == DONE);
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = state_q;

`ifdef AES_ENC_DBG_EN
  // Round counter is already 0 outside RUN.
  assign dbg_round = round_q;
  assign dbg_state = state_q;
`endif

endmodule

// File: tb/tb_aes_encrypt_iter.sv
// tb_aes_encrypt_iter: self-checking bench for aes_encrypt_iter. A byte-matrix
// AES model (S-box derived from GF(2^8) inversion) supplies expected values.
module tb_aes_encrypt_iter;
  localparam int unsigned NR = 10;
  localparam int unsigned KW = (NR + 1) * 128;

  logic          clk;
  logic          rst;
  logic [KW-1:0] all_keys;

  aes_encrypt_iter_if bus();

`ifdef AES_ENC_DBG_EN
  logic [3:0]   dbg_round;
  logic [127:0] dbg_state;
`endif

  aes_encrypt_iter #(.NK(4), .NR(10)) dut (
    .clk      (clk),
    .rst      (rst),
    .all_keys (all_keys),
    .bus      (bus)
`ifdef AES_ENC_DBG_EN
    ,
    .dbg_round(dbg_round),
    .dbg_state(dbg_state)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  int checks   = 0;
  int failures = 0;

  logic [7:0] sb_m  [256];
  logic [7:0] isb_m [256];

  typedef struct {
    logic [127:0] key;
    logic [127:0] pt;
    logic [127:0] ct;
  } vec_t;
  vec_t vecs [$];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  // S-box = affine(x^-1), inverse x^254; inverse table by reversal.
  task automatic build_tables();
    logic [7:0] inv, s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      if (x != 0) begin
        inv = 8'h01;
        for (int k = 0; k < 254; k++) inv = gmul(inv, 8'(x));
      end
      s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
          ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      sb_m[x]  = s;
      isb_m[s] = 8'(x);
    end
  endtask

  function automatic logic [KW-1:0] expand(input logic [127:0] key);
    logic [31:0]   w [44];
    logic [31:0]   t;
    logic [7:0]    rc;
    logic [KW-1:0] res;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb_m[t[31:24]], sb_m[t[23:16]], sb_m[t[15:8]], sb_m[t[7:0]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) res[128*r +: 128] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    return res;
  endfunction

  // Column transform with circulant coefficients base[(k-r) mod 4].
  function automatic logic [127:0] mix_m(input logic [127:0] v, input logic [31:0] base);
    logic [127:0] res;
    logic [7:0]   acc;
    logic [7:0]   co [4];
    co[0] = base[31:24]; co[1] = base[23:16]; co[2] = base[15:8]; co[3] = base[7:0];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int k = 0; k < 4; k++) acc = acc ^ gmul(co[(k - r + 4) % 4], v[127-8*(k+4*c) -: 8]);
        res[127-8*(r+4*c) -: 8] = acc;
      end
    return res;
  endfunction

  // Row rotation: dir=+1 encrypt (left by row index), dir=-1 decrypt.
  function automatic logic [127:0] shift_m(input logic [127:0] v, input int dir);
    logic [127:0] res;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        res[127-8*(r+4*c) -: 8] = v[127-8*(r+4*((c + dir*r + 8) % 4)) -: 8];
    return res;
  endfunction

  function automatic logic [127:0] sub_m(input logic [127:0] v, input bit inverse);
    logic [127:0] res;
    for (int k = 0; k < 16; k++) res[8*k +: 8] = inverse ? isb_m[v[8*k +: 8]] : sb_m[v[8*k +: 8]];
    return res;
  endfunction

  function automatic logic [127:0] model_enc(input logic [127:0] pt, input logic [KW-1:0] keys);
    logic [127:0] s;
    s = pt ^ keys[127:0];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      s = shift_m(sub_m(s, 1'b0), 1);
      if (rnd < 10) s = mix_m(s, 32'h02030101);
      s = s ^ keys[128*rnd +: 128];
    end
    return s;
  endfunction

  function automatic logic [127:0] model_dec(input logic [127:0] ct, input logic [KW-1:0] keys);
    logic [127:0] s;
    s = ct ^ keys[128*10 +: 128];
    for (int rnd = 9; rnd >= 0; rnd--) begin
      s = sub_m(shift_m(s, -1), 1'b1) ^ keys[128*rnd +: 128];
      if (rnd > 0) s = mix_m(s, 32'h0e0b0d09);
    end
    return s;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Step until out_valid (bounded); returns edges taken.
  task automatic wait_out(input int limit, output int n);
    n = 0;
    while (!bus.out_valid && n < limit) begin
      step();
      n++;
    end
  endtask

  // One block with out_ready held high: latency, data and one-cycle pulse.
  task automatic do_block(input logic [127:0] pt, input logic [127:0] exp,
                          input string name, output logic [127:0] got);
    int n;
    bus.out_ready = 1'b1;
    bus.in_data   = pt;
    bus.in_valid  = 1'b1;
    n = 0;
    while (!bus.in_ready && n < 40) begin
      step();
      n++;
    end
    chk({name, "_ready_wait"}, 128'(bus.in_ready), 128'(1));
    step();
    bus.in_valid = 1'b0;
    chk({name, "_busy"}, 128'(bus.in_ready), 128'(0));
    wait_out(20, n);
    chk({name, "_latency"}, 128'(n), 128'(10));
    chk({name, "_ct"}, bus.out_data, exp);
    got = bus.out_data;
    step();
    chk({name, "_pulse"}, 128'({bus.out_valid, bus.in_ready}), 128'(2'b01));
  endtask

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] ONES   = '1;

  initial begin
    logic [127:0] got, k, p, ff_exp;
    int           n;
    bit           ok;
    vec_t         v;

    build_tables();
    rst = 1'b1;
    all_keys = '0;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.out_ready = 1'b0;
    #2;
    chk("rst_in_ready", 128'(bus.in_ready), 128'(1));
    chk("rst_out_valid", 128'(bus.out_valid), 128'(0));
    chk("rst_out_data", bus.out_data, 128'(0));
`ifdef AES_ENC_DBG_EN
    chk("rst_dbg_round", 128'(dbg_round), 128'(0));
    chk("rst_dbg_state", dbg_state, 128'(0));
`endif
    step();
    step();
    rst = 1'b0;
    step();

    // Known-answer vectors followed by random ones scored by the model.
    vecs.push_back('{key: C1_KEY, pt: C1_PT, ct: C1_CT});
    vecs.push_back('{key: 128'h2b7e151628aed2a6abf7158809cf4f3c,
                     pt:  128'h3243f6a8885a308d313198a2e0370734,
                     ct:  128'h3925841d02dc09fbdc118597196a0b32});
    for (int i = 0; i < 8; i++) begin
      k = {$urandom, $urandom, $urandom, $urandom};
      p = {$urandom, $urandom, $urandom, $urandom};
      v.key = k;
      v.pt  = p;
      v.ct  = model_enc(p, expand(k));
      vecs.push_back(v);
    end
    for (int i = 0; i < vecs.size(); i++) begin
      all_keys = expand(vecs[i].key);
      do_block(vecs[i].pt, vecs[i].ct, $sformatf("vec%0d", i), got);
      chk($sformatf("vec%0d_roundtrip", i), model_dec(got, all_keys), vecs[i].pt);
    end

    // Output backpressure: result held five cycles, then released.
    all_keys = expand(C1_KEY);
    bus.out_ready = 1'b0;
    bus.in_data = C1_PT;
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    wait_out(20, n);
    chk("bp_latency", 128'(n), 128'(10));
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp_hold%0d", i), {bus.out_data[127:2], bus.out_valid, bus.in_ready},
          {C1_CT[127:2], 1'b1, 1'b0});
      step();
    end
    bus.out_ready = 1'b1;
    step();
    chk("bp_release", 128'({bus.out_valid, bus.in_ready}), 128'(2'b01));

    // Busy rejection: a second block offered during RUN waits for the handshake.
    bus.out_ready = 1'b0;
    bus.in_data = C1_PT;
    bus.in_valid = 1'b1;
    step();
`ifdef AES_ENC_DBG_EN
    chk("dbg_state_r1", dbg_state, 128'h00102030405060708090a0b0c0d0e0f0);
    chk("dbg_round_r1", 128'(dbg_round), 128'(1));
`endif
    bus.in_valid = 1'b0;
    step();
`ifdef AES_ENC_DBG_EN
    chk("dbg_state_r2", dbg_state, 128'h89d810e8855ace682d1843d8cb128fe4);
    chk("dbg_round_r2", 128'(dbg_round), 128'(2));
`endif
    step();
    bus.in_data = ONES;
    bus.in_valid = 1'b1;
    ok = 1'b1;
    n = 0;
    while (!bus.out_valid && n < 20) begin
      if (bus.in_ready) ok = 1'b0;
      step();
      n++;
    end
    chk("busy_no_accept", 128'(ok), 128'(1));
    chk("busy_first_ct", bus.out_data, C1_CT);
    bus.out_ready = 1'b1;
    step();
    chk("busy_handshake", 128'({bus.out_valid, bus.in_ready}), 128'(2'b01));
    step();
    bus.in_valid = 1'b0;
    chk("busy_pending_accept", 128'(bus.in_ready), 128'(0));
    ff_exp = model_enc(ONES, all_keys);
    wait_out(20, n);
    chk("busy_pending_latency", 128'(n), 128'(10));
    chk("busy_pending_ct", bus.out_data, ff_exp);
    step();

    // Reset in round 5 discards the block immediately.
    bus.in_data = C1_PT;
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 4; i++) step();
    rst = 1'b1;
    #1;
    chk("midrst_flags", 128'({bus.out_valid, bus.in_ready}), 128'(2'b01));
    chk("midrst_out_data", bus.out_data, 128'(0));
    step();
    rst = 1'b0;
    ok = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (bus.out_valid) ok = 1'b0;
      step();
    end
    chk("midrst_no_valid", 128'(ok), 128'(1));
    do_block(C1_PT, C1_CT, "after_rst", got);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
